// File: rtl/spi_flash_slave_if.sv
// Signal bundle between the SPI master / backing store and the spi_flash_slave
// responder: SPI pins, word-fetch port and status outputs.
interface spi_flash_slave_if #(
  parameter int ADDR_W = 24
) ();
  logic              spi_sck;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              err_underrun;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, mem_ack, mem_rdata,
    output spi_miso, mem_req, mem_addr, busy, err_underrun
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, mem_ack, mem_rdata,
    input  spi_miso, mem_req, mem_addr, busy, err_underrun
  );
endinterface

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash read responder: decodes READ, collects the address and
// streams prefetched 32-bit words MSB-first, oversampling SCK on the system clock.
module spi_flash_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] READ_CMD    = 8'h03,
  parameter int         ADDR_W      = 24
) (
  input logic              clock,
  input logic              reset,
  spi_flash_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  state_e                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [ADDR_W-2:0]      shift_q, shift_d;
  logic [31:0]            tx_buf_q, tx_buf_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   miso_q, miso_d;
  logic                   req_q, req_d;
  logic                   stale_q, stale_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic              sck_s, ss_s, mosi_s;
  logic              sck_rise_s, sck_fall_s, ack_s;
  logic [ADDR_W-1:0] sfull_s;
  logic [31:0]       word_s;
  logic              valid_s;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign ss_s       = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign ack_s      = bus.mem_ack & req_q;
  assign sfull_s    = {shift_q, mosi_s};

  // Next-state, fetch handshake and MISO data path
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_buf_d   = tx_buf_q;
    tx_valid_d = tx_valid_q;
    miso_d     = miso_q;
    req_d      = req_q;
    stale_d    = stale_q;
    addr_d     = addr_q;
    err_d      = err_q;
    busy_d     = ~ss_s;
    word_s     = tx_buf_q;
    valid_s    = tx_valid_q;

    // An ack always closes the outstanding request; an ack for a request that
    // belonged to an earlier select is discarded and, if a word is due, re-issued.
    if (ack_s) begin
      req_d   = 1'b0;
      stale_d = 1'b0;
      if (stale_q && !ss_s && (state_q == DATA) && !tx_valid_q) begin
        req_d = 1'b1;
      end else begin
        req_d = 1'b0;
      end
    end else begin
      req_d = req_q;
    end

    if (ss_s) begin
      state_d    = IDLE;
      miso_d     = 1'b0;
      tx_valid_d = 1'b0;
      cnt_d      = 6'd0;
      stale_d    = req_q & ~bus.mem_ack;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = 6'd0;
          shift_d = '0;
          err_d   = 1'b0;
          miso_d  = 1'b0;
        end
        CMD: begin
          if (sck_rise_s) begin
            shift_d = sfull_s[ADDR_W-2:0];
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              cnt_d   = 6'd0;
              state_d = (sfull_s[7:0] == READ_CMD) ? ADDR : IGNORE;
            end else begin
              state_d = CMD;
            end
          end else begin
            state_d = CMD;
          end
        end
        ADDR: begin
          if (sck_rise_s) begin
            shift_d = sfull_s[ADDR_W-2:0];
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'(ADDR_W - 1)) begin
              cnt_d      = 6'd0;
              addr_d     = {sfull_s[ADDR_W-1:2], 2'b00};
              req_d      = 1'b1;
              tx_valid_d = 1'b0;
              state_d    = DATA;
            end else begin
              state_d = ADDR;
            end
          end else begin
            state_d = ADDR;
          end
        end
        DATA: begin
          // A late ack skips the bits already clocked out for this word.
          if (ack_s && !stale_q) begin
            word_s  = bus.mem_rdata << cnt_q[4:0];
            valid_s = 1'b1;
          end else begin
            word_s  = tx_buf_q;
            valid_s = tx_valid_q;
          end
          tx_buf_d   = word_s;
          tx_valid_d = valid_s;
          if (sck_fall_s) begin
            miso_d   = valid_s & word_s[31];
            err_d    = err_q | ~valid_s;
            tx_buf_d = {word_s[30:0], 1'b0};
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q[4:0] == 5'd31) begin
              cnt_d      = 6'd0;
              addr_d     = addr_q + ADDR_W'(32'd4);
              req_d      = 1'b1;
              tx_valid_d = 1'b0;
            end else begin
              addr_d = addr_q;
            end
          end else begin
            miso_d = miso_q;
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  // Input synchronizers and state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      shift_q     <= '0;
      tx_buf_q    <= 32'd0;
      tx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      req_q       <= 1'b0;
      stale_q     <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sck_prev_q  <= sck_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_valid_q  <= tx_valid_d;
      miso_q      <= miso_d;
      req_q       <= req_d;
      stale_q     <= stale_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.spi_miso     = miso_q;
  assign bus.mem_req      = req_q;
  assign bus.mem_addr     = addr_q;
  assign bus.busy         = busy_q;
  assign bus.err_underrun = err_q;

endmodule

// File: doc/spi_flash_slave.md
Name: spi_flash_slave

Overview:
- SPI-mode-0 flash responder model: the far end of the APB-to-SPI XIP bridge. It receives the 8-bit command, decodes READ (0x03), and collects the 24-bit address.
- It fetches 32-bit words from a backing-store request/ack port and shifts them out MSB-first on MISO, auto-incrementing for burst reads.
- It sits in the perip tree between the SPI pads and the flash memory model, and is fully synchronous to the system clock (SCK is oversampled).

Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_sck, spi_ss, spi_mosi (minimum 2).
- READ_CMD, 8'h03, only command opcode that is served.
- ADDR_W, 24, address bits following the opcode.

Ports:
- clock input 1 system clock; all logic on the rising edge.
- reset input 1 asynchronous, active-high reset.
- spi_sck input 1 SPI clock from the master, idle low (mode 0).
- spi_ss input 1 chip select, active-low.
- spi_mosi input 1 master-out data.
- spi_miso output 1 slave-out data.
- mem_req output 1 fetch request; held high until mem_ack.
- mem_addr output ADDR_W word-aligned fetch address (bits [1:0] = 0).
- mem_ack input 1 one-cycle fetch completion; mem_rdata is valid in the same cycle.
- mem_rdata input 32 fetched word.
- busy output 1 high while selected (synchronized spi_ss low).
- err_underrun output 1 sticky; set when data was due but not fetched; cleared by reset or a new select.

Behaviour:
- Reset values:
  - spi_miso=0, mem_req=0, mem_addr=0, busy=0, err_underrun=0, state=IDLE.
  - All shift registers and bit counters are zero.
- Synchronization and edges:
  - Inputs pass through SYNC_STAGES flops.
  - sck_rise/sck_fall are derived from the last two synchronized SCK samples.
  - Requirement: SCK high and low phases are each at least SYNC_STAGES+2 clock cycles.
- Sampling and driving:
  - MOSI is sampled on sck_rise.
  - MISO is updated in the cycle after sck_fall.
- State machine (6-bit bit counter):
  - IDLE: wait for synced ss=0 → CMD; counter=0; err_underrun cleared.
  - CMD: shift MOSI in on 8 rises. After the 8th rise:
    - opcode==READ_CMD → ADDR;
    - else → IGNORE.
  - ADDR: shift 24 bits in, MSB first. After the 24th rise:
    - mem_addr = {addr[23:2],2'b00};
    - assert mem_req;
    - → DATA.
  - DATA:
    - On mem_ack: load mem_rdata into tx_buf, set tx_valid, drop mem_req.
    - On each sck_fall: drive tx_buf[31], shift left, increment bit index.
    - After the 32nd data fall: mem_addr += 4 (wraps modulo 2^ADDR_W), reassert mem_req, tx_valid cleared.
    - If a fall arrives while tx_valid=0: drive 0, set err_underrun, keep shifting the count so word alignment is preserved.
    - Late ack for the current word: bits already elapsed are dropped; the remaining bits are taken from the correct positions of mem_rdata.
  - IGNORE: spi_miso=0; no requests; wait for deselect.
- Deselect:
  - Synced ss=1 in any state → IDLE next cycle; spi_miso=0; busy=0.
  - A pending mem_req is held until mem_ack, then dropped; that data is discarded.
  - mem_req never deasserts before its ack.
- Address handling: the address byte offset (addr[1:0] ≠ 0) is ignored; the fetch is word-aligned.
- Simultaneous events:
  - mem_ack and sck_fall in the same cycle: the fall uses the newly acked data.
  - Deselect and sck_rise in the same cycle: deselect wins.
- SCK edges while deselected are ignored.
- A reset mid-transfer returns everything to reset values immediately.

Test Plan:
- Basic read: master sends 0x03_000010, clocks 32 data bits; mem returns 0xDEADBEEF with 1-cycle latency.
  - Required: mem_addr=0x000010; MISO stream = 0xDEADBEEF MSB first; err_underrun=0.
- Burst: same header with 64 data bits; words at 0x000010 = 0x11223344 and 0x000014 = 0x55667788.
  - Required: MISO = 0x1122334455667788; two requests seen.
- Bad opcode 0x9F followed by 56 clocks.
  - Required: no mem_req; MISO stays 0; busy=1 until ss high.
- Underrun: mem_ack withheld for the first 3 data falls, then 0xFFFFFFFF.
  - Required: first 3 MISO bits 0, remaining 29 bits 1; err_underrun=1.
  - A subsequent select clears err_underrun.
- Address wrap: address 0xFFFFFC with a 64-bit burst.
  - Required: second request at mem_addr=0x000000.
- Mid-transfer: deassert ss after 12 address bits, then reselect for a clean read of 0x000020.
  - Required: no stale request; correct data returned.
- Reset asserted mid-DATA.
  - Required: all outputs 0 within the same cycle.
